// File: rtl/breakpoint_buffer_if.sv
// breakpoint_buffer_if: write/serve bus between RX unit, segmentation stage and breakpoint_buffer.
//   master: drives Clear_buff, bp_write, bp_wdata, rx_done, bp_count, bp_ready
//   slave : drives bp_valid, bp_data, bp_last, serve_done, busy, overflow, order_err
interface breakpoint_buffer_if #(
    parameter int DATA_W = 64,
    parameter int BP_W   = 16
);
    logic              Clear_buff;
    logic              bp_write;
    logic [DATA_W-1:0] bp_wdata;
    logic              rx_done;
    logic [15:0]       bp_count;
    logic              bp_ready;
    logic              bp_valid;
    logic [BP_W-1:0]   bp_data;
    logic              bp_last;
    logic              serve_done;
    logic              busy;
    logic              overflow;
    logic              order_err;
    modport master (
        output Clear_buff, bp_write, bp_wdata, rx_done, bp_count, bp_ready,
        input  bp_valid, bp_data, bp_last, serve_done, busy, overflow, order_err
    );
    modport slave (
        input  Clear_buff, bp_write, bp_wdata, rx_done, bp_count, bp_ready,
        output bp_valid, bp_data, bp_last, serve_done, busy, overflow, order_err
    );
endinterface

// File: rtl/breakpoint_buffer.sv
// breakpoint_buffer: stores packed breakpoint words, then streams BP_W-bit entries over valid/ready.
//   clk_in, rst_n (async active-low), bus (breakpoint_buffer_if.slave).
//   Optional macro BP_ORDER_CHECK_EN adds a sticky non-increasing-entry detector (order_err).
module breakpoint_buffer #(
    parameter int DATA_W = 64,
    parameter int BP_W   = 16,
    parameter int WORDS  = 16,
    parameter int PTR_W  = $clog2(WORDS) + 1
) (
    input  logic                clk_in,
    input  logic                rst_n,
    breakpoint_buffer_if.slave  bus
);
    localparam int LANES = DATA_W / BP_W;
    localparam int WI_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LN_W  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, FILL, SERVE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [WORDS];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
    logic [15:0]       rd_idx_q, rd_idx_d, total_q, total_d, cap, nxt_idx;
    logic              valid_q, valid_d, last_q, last_d, done_q, done_d, ovf_q, ovf_d;
    logic [BP_W-1:0]   data_q, data_d, nxt_entry, first_entry;
    logic [DATA_W-1:0] nxt_word, first_word;
    logic              wr_ok, xfer;

    assign wr_ok      = bus.bp_write && state_q != SERVE && wr_ptr_q != PTR_W'(WORDS);
    assign xfer       = state_q == SERVE && valid_q && bus.bp_ready;
    assign wr_ptr_nxt = wr_ptr_q + PTR_W'(wr_ok);
    assign cap        = 16'(wr_ptr_nxt) * 16'(LANES);
    assign nxt_idx    = rd_idx_q + 16'd1;
    assign nxt_word   = mem_q[WI_W'(nxt_idx / 16'(LANES))];
    assign nxt_entry  = nxt_word[LN_W'(nxt_idx % 16'(LANES)) * BP_W +: BP_W];
    // Entry 0 must bypass the array when its word is being written in the rx_done cycle.
    assign first_word  = (wr_ok && wr_ptr_q == '0) ? bus.bp_wdata : mem_q[0];
    assign first_entry = first_word[BP_W-1:0];

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_nxt;
        rd_idx_d = rd_idx_q;
        total_d  = total_q;
        valid_d  = valid_q;
        last_d   = last_q;
        data_d   = data_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q || (bus.bp_write && !wr_ok);
        if (state_q != SERVE) begin
            state_d = wr_ok ? FILL : state_q;
            if (bus.rx_done) begin
                total_d  = (bus.bp_count < cap) ? bus.bp_count : cap;
                rd_idx_d = '0;
                if (total_d == 16'd0) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    wr_ptr_d = '0;
                end else begin
                    state_d = SERVE;
                    valid_d = 1'b1;
                    data_d  = first_entry;
                    last_d  = total_d == 16'd1;
                end
            end
        end else if (xfer) begin
            if (last_q) begin
                state_d  = IDLE;
                valid_d  = 1'b0;
                last_d   = 1'b0;
                done_d   = 1'b1;
                wr_ptr_d = '0;
                rd_idx_d = '0;
            end else begin
                rd_idx_d = nxt_idx;
                data_d   = nxt_entry;
                last_d   = nxt_idx == total_q - 16'd1;
            end
        end
        if (bus.Clear_buff) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_idx_d = '0;
            total_d  = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_idx_q <= '0;
            total_q  <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_idx_q <= rd_idx_d;
            total_q  <= total_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    // Data storage carries no reset; only words below wr_ptr are ever served.
    always_ff @(posedge clk_in) begin
        if (wr_ok && !bus.Clear_buff) mem_q[WI_W'(wr_ptr_q)] <= bus.bp_wdata;
    end

`ifdef BP_ORDER_CHECK_EN
    logic [BP_W-1:0] prev_q;
    logic            oerr_q;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            oerr_q <= 1'b0;
        end else if (bus.Clear_buff) begin
            oerr_q <= 1'b0;
        end else if (xfer) begin
            prev_q <= data_q;
            if (rd_idx_q != 16'd0 && data_q <= prev_q) oerr_q <= 1'b1;
        end
    end
    assign bus.order_err = oerr_q;
`else
    assign bus.order_err = 1'b0;
`endif

    assign bus.bp_valid   = valid_q;
    assign bus.bp_data    = data_q;
    assign bus.bp_last    = last_q;
    assign bus.serve_done = done_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_breakpoint_buffer.sv
// tb_breakpoint_buffer: directed vectors with hand-computed expectations for breakpoint_buffer.
module tb_breakpoint_buffer;
`ifdef BP_ORDER_CHECK_EN
    localparam logic OERR_EXP = 1'b1;
`else
    localparam logic OERR_EXP = 1'b0;
`endif
    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   idx;
    logic stall_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    breakpoint_buffer_if bus ();
    breakpoint_buffer dut (.clk_in(clk_in), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic wr(input logic [63:0] w);
        bus.bp_write = 1'b1;
        bus.bp_wdata = w;
        tick();
        bus.bp_write = 1'b0;
    endtask

    task automatic fin(input logic [15:0] c);
        bus.rx_done  = 1'b1;
        bus.bp_count = c;
        tick();
        bus.rx_done  = 1'b0;
    endtask

    task automatic take(input string tag, input logic [15:0] exp, input logic last);
        chk({tag, ".valid"}, 32'(bus.bp_valid), 32'd1);
        chk({tag, ".data"}, 32'(bus.bp_data), 32'(exp));
        chk({tag, ".last"}, 32'(bus.bp_last), 32'(last));
        bus.bp_ready = 1'b1;
        tick();
    endtask

    task automatic ended(input string tag);
        chk({tag, ".end_valid"}, 32'(bus.bp_valid), 32'd0);
        chk({tag, ".serve_done"}, 32'(bus.serve_done), 32'd1);
        chk({tag, ".end_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".valid"}, 32'(bus.bp_valid), 32'd0);
        chk({tag, ".data"}, 32'(bus.bp_data), 32'd0);
        chk({tag, ".last"}, 32'(bus.bp_last), 32'd0);
        chk({tag, ".serve_done"}, 32'(bus.serve_done), 32'd0);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'd0);
        chk({tag, ".order_err"}, 32'(bus.order_err), 32'd0);
    endtask

    initial begin
        bus.Clear_buff = 1'b0;
        bus.bp_write   = 1'b0;
        bus.bp_wdata   = '0;
        bus.rx_done    = 1'b0;
        bus.bp_count   = '0;
        bus.bp_ready   = 1'b1;
        repeat (2) tick();
        all_zero("reset");
        rst_n = 1'b1;
        tick();

        wr(64'h0004_0003_0002_0001);
        wr(64'h0008_0007_0006_0005);
        fin(16'd6);
        for (int i = 0; i < 6; i++) take($sformatf("basic%0d", i), 16'(i + 1), i == 5);
        ended("basic");
        tick();
        chk("basic.done_pulse", 32'(bus.serve_done), 32'd0);

        wr(64'h0004_0003_0002_0001);
        fin(16'd4);
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("stall%0d.data", k), 32'(bus.bp_data), 32'(idx + 1));
            bus.bp_ready = stall_pat[k];
            tick();
            if (stall_pat[k]) idx++;
        end
        ended("stall");
        bus.bp_ready = 1'b1;

        bus.Clear_buff = 1'b1;
        tick();
        bus.Clear_buff = 1'b0;
        for (int k = 0; k < 16; k++)
            wr({16'(4 * k + 4), 16'(4 * k + 3), 16'(4 * k + 2), 16'(4 * k + 1)});
        chk("full.no_overflow_yet", 32'(bus.overflow), 32'd0);
        wr(64'hDEAD_BEEF_CAFE_F00D);
        chk("full.overflow", 32'(bus.overflow), 32'd1);
        chk("full.busy", 32'(bus.busy), 32'd1);
        fin(16'd100);
        for (int i = 0; i < 64; i++) take($sformatf("clamp%0d", i), 16'(i + 1), i == 63);
        ended("clamp");
        chk("clamp.overflow_sticky", 32'(bus.overflow), 32'd1);
        bus.Clear_buff = 1'b1;
        tick();
        bus.Clear_buff = 1'b0;
        chk("clear.overflow", 32'(bus.overflow), 32'd0);

        bus.bp_write = 1'b1;
        bus.bp_wdata = 64'h0040_0030_0020_0010;
        bus.rx_done  = 1'b1;
        bus.bp_count = 16'd4;
        tick();
        bus.bp_write = 1'b0;
        bus.rx_done  = 1'b0;
        for (int i = 0; i < 4; i++) take($sformatf("same%0d", i), 16'(16 * (i + 1)), i == 3);
        ended("same");

        wr(64'h0004_0003_0002_0001);
        fin(16'd4);
        take("clr0", 16'd1, 1'b0);
        bus.bp_ready = 1'b0;
        bus.bp_write = 1'b1;
        bus.bp_wdata = '1;
        tick();
        bus.bp_write = 1'b0;
        chk("clr.serve_write_overflow", 32'(bus.overflow), 32'd1);
        chk("clr.hold_data", 32'(bus.bp_data), 32'd2);
        chk("clr.hold_valid", 32'(bus.bp_valid), 32'd1);
        bus.Clear_buff = 1'b1;
        tick();
        bus.Clear_buff = 1'b0;
        bus.bp_ready = 1'b1;
        chk("clr.valid", 32'(bus.bp_valid), 32'd0);
        chk("clr.busy", 32'(bus.busy), 32'd0);
        chk("clr.overflow", 32'(bus.overflow), 32'd0);
        chk("clr.last", 32'(bus.bp_last), 32'd0);
        fin(16'd4);
        ended("empty");

        wr(64'h0004_0003_0002_0001);
        fin(16'd4);
        take("rst0", 16'd1, 1'b0);
        rst_n = 1'b0;
        #1;
        all_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();
        wr(64'h000D_000C_000B_000A);
        fin(16'd2);
        take("rst.after0", 16'h000A, 1'b0);
        take("rst.after1", 16'h000B, 1'b1);
        ended("rst.after");

        wr({16'd0, 16'd9, 16'd9, 16'd5});
        fin(16'd3);
        take("ord0", 16'd5, 1'b0);
        take("ord1", 16'd9, 1'b0);
        chk("ord.before", 32'(bus.order_err), 32'd0);
        take("ord2", 16'd9, 1'b1);
        chk("ord.after", 32'(bus.order_err), 32'(OERR_EXP));
        ended("ord");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
